bcd_pulse_generator: RTL
========================

// Module: bcd_pulse_generator
// PURPOSE
//   Inverse of the pulse-counting path: takes a BCD digit (0-9) and emits exactly that many
//   clean pulses on one output, then flags completion. Drives valve/actuator step inputs and
//   lets a counter chain be self-tested in loopback (generator -> counter must read the digit back).
// PARAMETERS
//   PULSE_HIGH  1  cycles each pulse is held high (1..2**CNT_W)
//   PULSE_LOW   1  cycles of low gap after each pulse, including the last (1..2**CNT_W)
//   CNT_W       8  width of the internal phase timer
// PORTS
//   clk        in   1  single clock, all state updates on rising edge
//   reset      in   1  asynchronous, active-high; clears all state immediately
//   start      in   1  request; sampled only in IDLE
//   digit      in   4  BCD pulse count, captured on accepted start
//   pulse      out  1  generated pulse train (registered)
//   busy       out  1  high while in HIGH or LOW state
//   done       out  1  one-cycle strobe, burst complete
//   err        out  1  one-cycle strobe, start rejected (digit > 9)
//   remaining  out  4  pulses not yet started, registered
// BEHAVIOUR
//   - Reset (async assert): state=IDLE; pulse=0, busy=0, done=0, err=0, remaining=0, timer=0.
//   - States: IDLE, HIGH, LOW, DONE. All outputs registered; no combinational path in->out.
//   - IDLE, start=1, digit 1..9: next cycle -> HIGH, pulse=1, busy=1, remaining=digit-1,
//     timer loaded. Latency start->first pulse edge = 1 cycle.
//   - IDLE, start=1, digit=0: next cycle -> DONE (done=1), no pulse, busy stays 0.
//   - IDLE, start=1, digit 10..15: err=1 for one cycle, state stays IDLE, remaining unchanged.
//   - HIGH: after PULSE_HIGH cycles -> LOW, pulse=0.
//   - LOW: after PULSE_LOW cycles: remaining>0 -> HIGH, remaining-=1; remaining=0 -> DONE.
//   - DONE: done=1, busy=0 for exactly one cycle, then IDLE. start during DONE ignored.
//   - Burst length: N*(PULSE_HIGH+PULSE_LOW) busy cycles, then one done cycle.
//   - start while busy or in DONE: ignored, no effect on digit capture or outputs.
//   - Back-to-back: start held high continuously -> next burst accepted on first IDLE cycle
//     after DONE (one idle cycle minimum between bursts).
//   - remaining never wraps: decremented only when >0.
//   - Reset mid-burst: pulse drops asynchronously, no done strobe, burst discarded.
//   - done and err never assert in the same cycle; err only from IDLE.
// CONFIGURATION
//   PULSE_GEN_ABORT_EN defined: adds input port `abort` (1 bit, after digit). abort=1 in HIGH
//     or LOW -> next cycle pulse=0, busy=0, remaining=0, state -> DONE (done=1 one cycle).
//     abort in IDLE/DONE ignored; abort and start same IDLE cycle: start wins.
//   Undefined: no abort port; bursts always run to completion or reset.
// TESTING
//   1. H=2,L=1, start with digit=3 -> pulse 1,1,0 x3 over 9 cycles from cycle+1, done at cycle 10.
//   2. digit=0 start -> done=1 next cycle, pulse never high, busy never high.
//   3. digit=12 start -> err=1 one cycle, no pulse, state IDLE, remaining=0.
//   4. start=1 with digit=9 mid-burst of digit=2 -> exactly 2 pulses, 9 ignored.
//   5. reset asserted during 2nd pulse of digit=5 -> pulse/busy/remaining 0 at once, no done.
//   6. Loopback: digit 0..9 each into counter chain -> counter reads back digit; with
//      PULSE_GEN_ABORT_EN, abort after 1st pulse of digit=7 -> done next cycle, counter reads 1.

Source files
------------

// File: rtl/bcd_pulse_generator.sv
// BCD-to-pulse-train generator: emits `digit` pulses (PULSE_HIGH high, PULSE_LOW low each), then a done strobe.
// Define PULSE_GEN_ABORT_EN to add an `abort` input that cuts a running burst short.
module bcd_pulse_generator #(
    parameter int PULSE_HIGH = 1,
    parameter int PULSE_LOW  = 1,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] digit,
`ifdef PULSE_GEN_ABORT_EN
    input  logic       abort,
`endif
    output logic       pulse,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] remaining
);

    // state | meaning
    // IDLE  | waiting for start, the only state that samples start/digit
    // HIGH  | pulse held high, phase timer counting down PULSE_HIGH cycles
    // LOW   | gap after a pulse, phase timer counting down PULSE_LOW cycles
    // DONE  | one-cycle completion strobe, returns to IDLE
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Timer is loaded with length-1 and the phase ends on the cycle it reads zero.
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(PULSE_HIGH - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(PULSE_LOW - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMER_TC  = '0;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic [3:0]       rem_nx;
    logic             err_nx;
    logic             abort_req;

`ifdef PULSE_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        rem_nx   = remaining;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (digit > 4'd9) begin
                        err_nx = 1'b1;
                    end else if (digit == 4'd0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = HIGH;
                        rem_nx   = digit - 4'd1;
                        timer_nx = HIGH_LOAD;
                    end
                end
            end
            HIGH: begin
                if (abort_req) begin
                    state_nx = DONE;
                    rem_nx   = 4'd0;
                end else if (timer == TIMER_TC) begin
                    state_nx = LOW;
                    timer_nx = LOW_LOAD;
                end else begin
                    timer_nx = timer - TIMER_ONE;
                end
            end
            LOW: begin
                if (abort_req) begin
                    state_nx = DONE;
                    rem_nx   = 4'd0;
                end else if (timer == TIMER_TC) begin
                    if (remaining != 4'd0) begin
                        state_nx = HIGH;
                        rem_nx   = remaining - 4'd1;
                        timer_nx = HIGH_LOAD;
                    end else begin
                        state_nx = DONE;
                    end
                end else begin
                    timer_nx = timer - TIMER_ONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            remaining <= 4'd0;
            pulse     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            remaining <= rem_nx;
            pulse     <= (state_nx == HIGH);
            busy      <= (state_nx == HIGH) || (state_nx == LOW);
            done      <= (state_nx == DONE);
            err       <= err_nx;
        end
    end

endmodule
